// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and types for the sweep tone channel.
package tone_pkg;
    localparam int DUTY_W = 2;
    localparam int STEP_W = 3;
    typedef enum logic {SWEEP_ADD = 1'b0, SWEEP_SUB = 1'b1} sweep_mode_e;
    localparam logic [3:0][7:0] DUTY_LUT = {8'b1111_1100, 8'b0000_1111, 8'b0000_0011, 8'b0000_0001};
endpackage

// File: rtl/sweep_unit.sv
// sweep_unit: sweep tick synchroniser, rate divider and next-period target.
module sweep_unit
    import tone_pkg::*;
#(
    parameter int PERIOD_W = 11,
    parameter int SHIFT_W  = 3,
    parameter int RATE_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iSweep_clk,
    input  logic                iSweep_mode,
    input  logic [SHIFT_W-1:0]  iSweep_shift,
    input  logic [RATE_W-1:0]   iSweep_rate,
    input  logic                iSweep_restart,
    input  logic                iPeriod_load,
    input  logic [PERIOD_W-1:0] cur_period_i,
    output logic                update_o,
    output logic [PERIOD_W-1:0] target_o,
    output logic                ovf_o
);
    logic s1_q, s2_q, prev_q, tick;
    logic [RATE_W-1:0] div_q, div_d;
    logic [PERIOD_W:0] cur_x, delta, target;
    always_comb begin
        tick     = s2_q & ~prev_q;
        cur_x    = {1'b0, cur_period_i};
        delta    = cur_x >> iSweep_shift;
        target   = (iSweep_mode == SWEEP_SUB) ? cur_x - delta : cur_x + delta;
        // load and restart both swallow a coincident tick
        div_d    = (iPeriod_load | iSweep_restart) ? iSweep_rate :
                   !tick ? div_q :
                   (div_q == '0) ? iSweep_rate : div_q - RATE_W'(1);
        update_o = tick & ~iPeriod_load & ~iSweep_restart & (div_q == '0);
        ovf_o    = (iSweep_mode == SWEEP_ADD) & target[PERIOD_W];
        target_o = target[PERIOD_W-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            div_q  <= '0;
        end else begin
            s1_q   <= iSweep_clk;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            div_q  <= div_d;
        end
    end
endmodule

// File: rtl/sweep_tone_gen.sv
// sweep_tone_gen: square-wave tone channel with duty sequencer and frequency sweep.
module sweep_tone_gen
    import tone_pkg::*;
#(
    parameter int PERIOD_W     = 11,
    parameter int SHIFT_W      = 3,
    parameter int RATE_W       = 3,
    parameter int MIN_PERIOD   = 8,
    parameter int RESET_PERIOD = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] iPeriod,
    input  logic                iPeriod_load,
    input  logic [DUTY_W-1:0]   iDuty,
    input  logic                iSweep_clk,
    input  logic                iSweep_enable,
    input  logic                iSweep_mode,
    input  logic [SHIFT_W-1:0]  iSweep_shift,
    input  logic [RATE_W-1:0]   iSweep_rate,
    input  logic                iSweep_restart,
    output logic                oData,
    output logic                oMute,
    output logic [PERIOD_W-1:0] oPeriod
);
    logic [PERIOD_W-1:0] cur_q, cur_d, timer_q, timer_d, target;
    logic [STEP_W-1:0] step_q, step_d;
    logic data_q, data_d, mute, ovf, update;
    sweep_unit #(
        .PERIOD_W(PERIOD_W),
        .SHIFT_W (SHIFT_W),
        .RATE_W  (RATE_W)
    ) u_sweep (
        .clk           (clk),
        .reset         (reset),
        .iSweep_clk    (iSweep_clk),
        .iSweep_mode   (iSweep_mode),
        .iSweep_shift  (iSweep_shift),
        .iSweep_rate   (iSweep_rate),
        .iSweep_restart(iSweep_restart),
        .iPeriod_load  (iPeriod_load),
        .cur_period_i  (cur_q),
        .update_o      (update),
        .target_o      (target),
        .ovf_o         (ovf)
    );
    always_comb begin
        mute    = (cur_q < PERIOD_W'(MIN_PERIOD)) | ovf;
        cur_d   = iPeriod_load ? iPeriod :
                  (update & iSweep_enable & (|iSweep_shift) & ~mute) ? target : cur_q;
        // reload uses the period in force now; a sweep update shows on the next reload
        timer_d = iPeriod_load ? iPeriod : (timer_q == '0) ? cur_q : timer_q - PERIOD_W'(1);
        step_d  = iPeriod_load ? '0 : (timer_q == '0) ? step_q + STEP_W'(1) : step_q;
        data_d  = DUTY_LUT[iDuty][step_q] & ~mute;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q   <= PERIOD_W'(RESET_PERIOD);
            timer_q <= PERIOD_W'(RESET_PERIOD);
            step_q  <= '0;
            data_q  <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            data_q  <= data_d;
        end
    end
    assign oData   = data_q;
    assign oMute   = mute;
    assign oPeriod = cur_q;
endmodule

// File: tb/tb_sweep_tone_gen.sv
// tb_sweep_tone_gen: directed self-checking bench for sweep_tone_gen.
module tb_sweep_tone_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] iPeriod = '0;
    logic        iPeriod_load = 1'b0;
    logic [1:0]  iDuty = 2'd2;
    logic        iSweep_clk = 1'b0;
    logic        iSweep_enable = 1'b0;
    logic        iSweep_mode = 1'b0;
    logic [2:0]  iSweep_shift = '0;
    logic [2:0]  iSweep_rate = '0;
    logic        iSweep_restart = 1'b0;
    logic        oData, oMute;
    logic [10:0] oPeriod;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sweep_tone_gen dut (
        .clk           (clk),
        .reset         (reset),
        .iPeriod       (iPeriod),
        .iPeriod_load  (iPeriod_load),
        .iDuty         (iDuty),
        .iSweep_clk    (iSweep_clk),
        .iSweep_enable (iSweep_enable),
        .iSweep_mode   (iSweep_mode),
        .iSweep_shift  (iSweep_shift),
        .iSweep_rate   (iSweep_rate),
        .iSweep_restart(iSweep_restart),
        .oData         (oData),
        .oMute         (oMute),
        .oPeriod       (oPeriod)
    );

    task automatic do_load(input logic [10:0] p);
        @(negedge clk);
        iPeriod = p;
        iPeriod_load = 1'b1;
        @(negedge clk);
        iPeriod_load = 1'b0;
    endtask

    task automatic sweep_tick();
        iSweep_clk = 1'b1;
        repeat (4) @(negedge clk);
        iSweep_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic measure(output int hi, output int per);
        int n = 0;
        while (oData !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        while (oData !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        hi = 0;
        while (oData === 1'b1 && n < 3000) begin hi++; @(negedge clk); n++; end
        per = hi;
        while (oData !== 1'b1 && n < 3000) begin per++; @(negedge clk); n++; end
        if (n >= 3000) begin hi = -1; per = -1; end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (oData !== 1'b0) begin errors++; $display("FAIL reset_data got %0b want 0", oData); end
        vectors++; if (oPeriod !== 11'd0) begin errors++; $display("FAIL reset_period got %0d want 0", oPeriod); end
        vectors++; if (oMute !== 1'b1) begin errors++; $display("FAIL reset_mute got %0b want 1", oMute); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_duty();
        int hi, per;
        int want_hi [3] = '{404, 101, 606};
        logic [1:0] duty [3] = '{2'd2, 2'd0, 2'd3};
        iSweep_enable = 1'b0;
        iDuty = 2'd2;
        do_load(11'd100);
        vectors++; if (oMute !== 1'b0) begin errors++; $display("FAIL duty_mute got %0b want 0", oMute); end
        for (int i = 0; i < 3; i++) begin
            iDuty = duty[i];
            measure(hi, per);
            vectors++; if (per !== 808) begin errors++; $display("FAIL duty%0d_period got %0d want 808", duty[i], per); end
            vectors++; if (hi !== want_hi[i]) begin errors++; $display("FAIL duty%0d_high got %0d want %0d", duty[i], hi, want_hi[i]); end
        end
        iDuty = 2'd2;
    endtask

    task automatic test_low_mute();
        int seen = 0;
        do_load(11'd5);
        vectors++; if (oMute !== 1'b1) begin errors++; $display("FAIL low_mute got %0b want 1", oMute); end
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (oData !== 1'b0) seen++; end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL low_data high_samples got %0d want 0", seen); end
        do_load(11'd8);
        vectors++; if (oMute !== 1'b0) begin errors++; $display("FAIL min_unmute got %0b want 0", oMute); end
    endtask

    task automatic test_overflow();
        iSweep_mode = 1'b0;
        iSweep_shift = 3'd0;
        iSweep_rate = 3'd0;
        iSweep_enable = 1'b1;
        do_load(11'd1024);
        vectors++; if (oMute !== 1'b1) begin errors++; $display("FAIL ovf_mute got %0b want 1", oMute); end
        sweep_tick();
        sweep_tick();
        vectors++; if (oPeriod !== 11'd1024) begin errors++; $display("FAIL ovf_hold got %0d want 1024", oPeriod); end
        iSweep_shift = 3'd1;
        @(negedge clk);
        vectors++; if (oMute !== 1'b0) begin errors++; $display("FAIL shift1_unmute got %0b want 0", oMute); end
        sweep_tick();
        vectors++; if (oPeriod !== 11'd1536) begin errors++; $display("FAIL shift1_update got %0d want 1536", oPeriod); end
        vectors++; if (oMute !== 1'b1) begin errors++; $display("FAIL next_ovf_mute got %0b want 1", oMute); end
    endtask

    task automatic test_sweep_sub();
        logic [10:0] want [4] = '{11'd512, 11'd384, 11'd384, 11'd288};
        iSweep_mode = 1'b1;
        iSweep_shift = 3'd2;
        iSweep_rate = 3'd1;
        iSweep_enable = 1'b1;
        do_load(11'd512);
        for (int i = 0; i < 4; i++) begin
            sweep_tick();
            vectors++; if (oPeriod !== want[i]) begin errors++; $display("FAIL sub_tick%0d got %0d want %0d", i + 1, oPeriod, want[i]); end
        end
    endtask

    task automatic test_load_tick();
        logic [10:0] want [3] = '{11'd200, 11'd200, 11'd100};
        iSweep_mode = 1'b1;
        iSweep_shift = 3'd1;
        iSweep_rate = 3'd0;
        iSweep_enable = 1'b1;
        do_load(11'd300);
        iSweep_rate = 3'd2;
        @(negedge clk);
        iSweep_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        iPeriod = 11'd200;
        iPeriod_load = 1'b1;
        @(negedge clk);
        iPeriod_load = 1'b0;
        vectors++; if (oPeriod !== 11'd200) begin errors++; $display("FAIL load_tick got %0d want 200", oPeriod); end
        repeat (2) @(negedge clk);
        iSweep_clk = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sweep_tick();
            vectors++; if (oPeriod !== want[i]) begin errors++; $display("FAIL load_div_tick%0d got %0d want %0d", i + 1, oPeriod, want[i]); end
        end
    endtask

    task automatic test_restart();
        iSweep_rate = 3'd1;
        @(negedge clk);
        iSweep_restart = 1'b1;
        @(negedge clk);
        iSweep_restart = 1'b0;
        sweep_tick();
        vectors++; if (oPeriod !== 11'd100) begin errors++; $display("FAIL restart_tick1 got %0d want 100", oPeriod); end
        sweep_tick();
        vectors++; if (oPeriod !== 11'd50) begin errors++; $display("FAIL restart_tick2 got %0d want 50", oPeriod); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        iSweep_enable = 1'b0;
        iSweep_mode = 1'b0;
        iSweep_shift = 3'd0;
        iDuty = 2'd2;
        do_load(11'd100);
        while (oData !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        vectors++; if (oData !== 1'b1) begin errors++; $display("FAIL mid_wait_high got %0b want 1", oData); end
        #3 reset = 1'b1;
        #1;
        vectors++; if (oData !== 1'b0) begin errors++; $display("FAIL async_data got %0b want 0", oData); end
        vectors++; if (oPeriod !== 11'd0) begin errors++; $display("FAIL async_period got %0d want 0", oPeriod); end
        vectors++; if (oMute !== 1'b1) begin errors++; $display("FAIL async_mute got %0b want 1", oMute); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_duty();
        test_low_mute();
        test_overflow();
        test_sweep_sub();
        test_load_tick();
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
